// File: rtl/dmem_bridge.sv
// Data-side bridge from the MEM stage to the SRAM-like handshake bus: one
// outstanding transaction, split address/data phases. Define DMEM_ADDR_MAP_EN for kseg0/kseg1 mapping.
module dmem_bridge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata_last,
  input  logic [3:0]  sel,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_excepttype,
  input  logic        mem_flush,
  input  logic        other_stall,
  output logic        stallreq_from_mem,
  output logic [31:0] mem_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        access;
  logic [31:0] phys_addr;

  assign access = mem_en & (mem_excepttype == 32'd0) & ~mem_flush;

`ifdef DMEM_ADDR_MAP_EN
  assign phys_addr = (mem_addr[31:29] == 3'b100 || mem_addr[31:29] == 3'b101) ?
                     {3'b000, mem_addr[28:0]} : mem_addr;
`else
  assign phys_addr = mem_addr;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (access) state_d = data_addr_ok ? DATA : ADDR;
      end
      ADDR: begin
        if (mem_flush)         state_d = IDLE;
        else if (data_addr_ok) state_d = DATA;
      end
      DATA: begin
        // A flush coinciding with data_ok drops the data and skips DRAIN.
        if (data_data_ok) begin
          if (mem_flush) begin
            state_d = IDLE;
          end else begin
            rdata_d = data_rdata;
            state_d = other_stall ? DONE : IDLE;
          end
        end else if (mem_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (data_data_ok) state_d = IDLE;
      end
      DONE: begin
        if (!other_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    data_req          = ((state_q == IDLE) & access) | (state_q == ADDR);
    stallreq_from_mem = ((state_q == IDLE) & access) | (state_q == ADDR) |
                        ((state_q == DATA) & ~data_data_ok) | ((state_q == DRAIN) & mem_en);
    mem_rdata         = ((state_q == DATA) & data_data_ok) ? data_rdata : rdata_q;
    data_wr           = 1'b0;
    data_size         = 2'd0;
    data_addr         = 32'd0;
    data_wstrb        = 4'd0;
    data_wdata        = 32'd0;
    if (data_req) begin
      data_wr    = mem_we;
      data_size  = mem_size;
      data_addr  = phys_addr;
      data_wstrb = mem_we ? sel : 4'd0;
      data_wdata = mem_wdata_last;
    end
  end

endmodule
